// File: rtl/light_show_pkg.sv
// ----------------------------------------------------------------------------
// light_show_pkg
// Shared definitions for the light-show controller: FSM state type, mode
// encodings, colour range constants and small helper functions.
// ----------------------------------------------------------------------------
package light_show_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StManual,
      StCycleWait,
      StCyclePress,
      StBlink
   } state_e;

   localparam logic [1:0] MODE_MANUAL = 2'b00;
   localparam logic [1:0] MODE_CYCLE  = 2'b01;
   localparam logic [1:0] MODE_BLINK  = 2'b10;
   localparam logic [1:0] MODE_HOLD   = 2'b11;

   localparam int unsigned N_COLOURS_DEFAULT = 6;
   localparam int unsigned COLOUR_MIN        = 1;
   localparam int unsigned COLOUR_MAX        = N_COLOURS_DEFAULT;

   // Next colour number of the selector, wrapping from n_max back to COLOUR_MIN.
   function automatic logic [2:0] colour_next(input logic [2:0] idx, input int unsigned n_max);
      logic [2:0] res;
      if (idx >= 3'(n_max)) res = 3'(COLOUR_MIN);
      else                  res = idx + 3'd1;
      return res;
   endfunction

   // HOLD shares the MANUAL state; its inputs are ignored there.
   function automatic state_e mode_state(input logic [1:0] mode);
      state_e res;
      case (mode)
         MODE_CYCLE: res = StCycleWait;
         MODE_BLINK: res = StBlink;
         default:    res = StManual;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/dwell_timer.sv
// ----------------------------------------------------------------------------
// dwell_timer
// Clearable up-counter with a terminal-count flag. o_tc is high while the
// count has reached max(i_dwell,1)-1, i.e. on the last cycle of the period.
// Ports:
//   i_clk    clock
//   i_rst    synchronous active-high reset (count -> 0)
//   i_clear  clear the count (priority over i_inc)
//   i_inc    advance the count by one
//   i_dwell  period length in cycles (0 treated as 1)
//   o_tc     terminal count reached
// ----------------------------------------------------------------------------
module dwell_timer #(
   parameter int unsigned DWELL_W = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_clear,
   input  logic               i_inc,
   input  logic [DWELL_W-1:0] i_dwell,
   output logic               o_tc
);

   logic [DWELL_W-1:0] r_count;
   logic [DWELL_W-1:0] w_limit;

   // Compared live against i_dwell so a shortened period expires at once.
   always_comb begin
      w_limit = '0;
      if (i_dwell != '0) w_limit = i_dwell - DWELL_W'(1);
   end

   assign o_tc = (r_count >= w_limit);

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) r_count <= '0;
      else if (i_inc)       r_count <= r_count + DWELL_W'(1);
   end

endmodule

// File: rtl/light_show_ctrl.sv
// ----------------------------------------------------------------------------
// light_show_ctrl
// Drives the button/sel inputs of a downstream lights selector in one of four
// modes (MANUAL, CYCLE, BLINK, HOLD) and keeps a shadow of its colour number.
// Ports:
//   i_clk          clock (rising edge)
//   i_rst          synchronous active-high reset
//   i_enable       run enable; 0 forces IDLE
//   i_mode         00 MANUAL, 01 CYCLE, 10 BLINK, 11 HOLD
//   i_dwell        CYCLE/BLINK period in cycles (0 treated as 1)
//   i_man_button   manual button request (MANUAL only)
//   i_man_sel      manual white/colour select (MANUAL only)
//   o_button       registered button drive
//   o_sel          registered sel drive (1 = white, 0 = colour)
//   o_colour_idx   shadow colour number, 1..N_COLOURS
//   o_busy         high in every state except IDLE
// ----------------------------------------------------------------------------
module light_show_ctrl
   import light_show_pkg::*;
#(
   parameter int unsigned DWELL_W   = 8,
   parameter int unsigned N_COLOURS = COLOUR_MAX
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_enable,
   input  logic [1:0]         i_mode,
   input  logic [DWELL_W-1:0] i_dwell,
   input  logic               i_man_button,
   input  logic               i_man_sel,
   output logic               o_button,
   output logic               o_sel,
   output logic [2:0]         o_colour_idx,
   output logic               o_busy
);

   state_e     r_state;
   state_e     w_state_d;
   logic       r_button, w_button_d;
   logic       r_sel, w_sel_d;
   logic [2:0] r_colour, w_colour_d;
   logic       r_busy;
   logic [1:0] r_mode;
   logic       w_tmr_clear, w_tmr_inc, w_tmr_tc;

   dwell_timer #(
      .DWELL_W (DWELL_W)
   ) u_dwell_timer (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clear (w_tmr_clear),
      .i_inc   (w_tmr_inc),
      .i_dwell (i_dwell),
      .o_tc    (w_tmr_tc)
   );

   always_comb begin
      w_state_d   = r_state;
      w_button_d  = 1'b0;
      w_sel_d     = r_sel;
      w_tmr_clear = 1'b0;
      w_tmr_inc   = 1'b0;
      // The shadow follows the selector, which steps on each cycle the
      // registered button is high.
      w_colour_d  = r_button ? colour_next(r_colour, N_COLOURS) : r_colour;

      if (!i_enable) begin
         w_state_d   = StIdle;
         w_sel_d     = 1'b0;
         w_tmr_clear = 1'b1;
      end else if (r_state == StIdle || i_mode != r_mode) begin
         // Entry into a mode: fresh timer and no button, so no partial press.
         w_state_d   = mode_state(i_mode);
         w_tmr_clear = 1'b1;
         if (i_mode == MODE_CYCLE || i_mode == MODE_BLINK) w_sel_d = 1'b0;
      end else begin
         case (r_state)
            StManual: begin
               if (i_mode == MODE_MANUAL) begin
                  w_button_d = i_man_button;
                  w_sel_d    = i_man_sel;
               end
            end
            StCycleWait: begin
               w_sel_d = 1'b0;
               if (w_tmr_tc) begin
                  w_state_d   = StCyclePress;
                  w_button_d  = 1'b1;
                  w_tmr_clear = 1'b1;
               end else begin
                  w_tmr_inc = 1'b1;
               end
            end
            StCyclePress: begin
               w_state_d   = StCycleWait;
               w_sel_d     = 1'b0;
               w_tmr_clear = 1'b1;
            end
            StBlink: begin
               if (w_tmr_tc) begin
                  w_sel_d     = ~r_sel;
                  w_tmr_clear = 1'b1;
               end else begin
                  w_tmr_inc = 1'b1;
               end
            end
            default: begin
               w_state_d   = StIdle;
               w_sel_d     = 1'b0;
               w_tmr_clear = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= StIdle;
         r_button <= 1'b0;
         r_sel    <= 1'b0;
         r_colour <= 3'(COLOUR_MIN);
         r_busy   <= 1'b0;
         r_mode   <= MODE_MANUAL;
      end else begin
         r_state  <= w_state_d;
         r_button <= w_button_d;
         r_sel    <= w_sel_d;
         r_colour <= w_colour_d;
         r_busy   <= (w_state_d != StIdle);
         r_mode   <= i_mode;
      end
   end

   assign o_button     = r_button;
   assign o_sel        = r_sel;
   assign o_colour_idx = r_colour;
   assign o_busy       = r_busy;

endmodule
